// File: rtl/nco_ctrl_pkg.sv
// Shared constants and state encoding for the NCO hop controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nco_ctrl_pkg;

  localparam int PHI_W_DEF      = 32;
  localparam int TBL_DEPTH_DEF  = 8;
  localparam int DWELL_W_DEF    = 16;
  localparam int SETTLE_CYC_DEF = 4;

  // Sequencer states, kept as plain 3-bit constants so older tools and
  // waveform scripts see stable codes.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_APPLY  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Index width for a table/counter of 'depth' entries, never below 1 bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nco_hop_ctrl_if.sv
// Bundles the hop controller's config, control and NCO-facing signals.
// Latency: n/a (wires only).
// Backpressure: n/a; the NCO side uses nco_valid_i as its only qualifier.
//   master : drives config/control and nco_valid_i, observes the controller
//   slave  : the controller itself
interface nco_hop_ctrl_if
  import nco_ctrl_pkg::*;
#(
  parameter int PHI_W     = PHI_W_DEF,
  parameter int TBL_DEPTH = TBL_DEPTH_DEF,
  parameter int DWELL_W   = DWELL_W_DEF
);
  localparam int AW = idx_w(TBL_DEPTH);

  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [PHI_W-1:0]   cfg_data;
  logic [AW-1:0]      last_idx;
  logic [DWELL_W-1:0] dwell;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               nco_valid_i;
  logic [PHI_W-1:0]   phi_inc_o;
  logic               nco_clken_o;
  logic [AW-1:0]      hop_idx_o;
  logic               hop_strobe_o;
  logic               sample_en_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output cfg_we, cfg_addr, cfg_data, last_idx, dwell, loop_en, start, stop,
           nco_valid_i,
    input  phi_inc_o, nco_clken_o, hop_idx_o, hop_strobe_o, sample_en_o,
           busy_o, done_o
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, last_idx, dwell, loop_en, start, stop,
           nco_valid_i,
    output phi_inc_o, nco_clken_o, hop_idx_o, hop_strobe_o, sample_en_o,
           busy_o, done_o
  );

endinterface

// File: rtl/nco_hop_table.sv
// Hop table: phase increments written by config, read by the sequencer.
// Latency: write visible one cycle after the strobe; read is combinational.
// Backpressure: none; writes are accepted every cycle.
//   clk, reset_n      : clock, async active-low reset (clears all entries)
//   we, waddr, wdata  : synchronous write port
//   raddr, rdata      : asynchronous read port
module nco_hop_table
  import nco_ctrl_pkg::*;
#(
  parameter int PHI_W     = PHI_W_DEF,
  parameter int TBL_DEPTH = TBL_DEPTH_DEF,
  parameter int AW        = idx_w(TBL_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PHI_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PHI_W-1:0] rdata
);

  logic [PHI_W-1:0] mem [TBL_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < TBL_DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses (non power-of-two depth) read as zero.
  assign rdata = (32'(raddr) < TBL_DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/nco_hop_ctrl.sv
// Frequency-hop sequencer: walks the hop table, lets the NCO settle, counts dwell samples.
// Latency: phi_inc_o updates 1 cycle after APPLY; RUN starts SETTLE_CYC cycles later.
// Backpressure: none; nco_valid_i qualifies samples, stop aborts the next cycle.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : table config, sequence control, NCO phi_inc/clken/valid, status
module nco_hop_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int PHI_W      = PHI_W_DEF,
  parameter int TBL_DEPTH  = TBL_DEPTH_DEF,
  parameter int DWELL_W    = DWELL_W_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  nco_hop_ctrl_if.slave bus
);

  localparam int            AW       = idx_w(TBL_DEPTH);
  localparam int            SW       = idx_w(SETTLE_CYC + 1);
  localparam logic [AW-1:0] LAST_MAX = AW'(TBL_DEPTH - 1);

  state_t             state;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      last_s;
  logic [DWELL_W-1:0] dwell_s;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [SW-1:0]      settle_cnt;
  logic [PHI_W-1:0]   phi_q;
  logic [PHI_W-1:0]   tbl_rd;
  logic               strobe_q;

  logic [AW-1:0]      last_clamped;
  logic [DWELL_W-1:0] dwell_eff;
  logic               samp;
  logic               hop_done;

  nco_hop_table #(
    .PHI_W     (PHI_W),
    .TBL_DEPTH (TBL_DEPTH),
    .AW        (AW)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (bus.cfg_we),
    .waddr   (bus.cfg_addr),
    .wdata   (bus.cfg_data),
    .raddr   (idx),
    .rdata   (tbl_rd)
  );

  always_comb begin
    last_clamped = (bus.last_idx > LAST_MAX) ? LAST_MAX : bus.last_idx;
    // A dwell of 0 behaves as 1 so every hop consumes at least one sample.
    dwell_eff    = (dwell_s == '0) ? DWELL_W'(1) : dwell_s;
    samp         = (state == ST_RUN) && bus.nco_valid_i;
    hop_done     = samp && (dwell_cnt == dwell_eff - DWELL_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      last_s     <= '0;
      dwell_s    <= '0;
      dwell_cnt  <= '0;
      settle_cnt <= '0;
      phi_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // stop overrides every transition, including the APPLY load, so the
      // NCO keeps whatever increment it was already running.
      if (bus.stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state   <= ST_APPLY;
              idx     <= '0;
              last_s  <= last_clamped;
              dwell_s <= bus.dwell;
            end
          end
          ST_APPLY: begin
            // Table read is combinational, so a same-cycle write to this
            // address lands after the load: the old value is used.
            phi_q      <= tbl_rd;
            strobe_q   <= 1'b1;
            settle_cnt <= SW'(SETTLE_CYC - 1);
            state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              state     <= ST_RUN;
              dwell_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
          ST_RUN: begin
            if (hop_done) begin
              if (idx < last_s) begin
                idx   <= idx + AW'(1);
                state <= ST_APPLY;
              end else if (bus.loop_en) begin
                idx   <= '0;
                state <= ST_APPLY;
              end else begin
                state <= ST_DONE;
              end
            end else if (samp) begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.phi_inc_o    = phi_q;
  assign bus.hop_idx_o    = idx;
  assign bus.hop_strobe_o = strobe_q;
  assign bus.sample_en_o  = samp;
  assign bus.busy_o       = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_RUN);
  assign bus.nco_clken_o  = bus.busy_o;
  assign bus.done_o       = (state == ST_DONE);

endmodule

// File: tb/tb_nco_hop_ctrl.sv
// Self-checking bench for nco_hop_ctrl: directed scenario table, reset and
// stop corner cases, then randomized sequences against a hop-walk model.
module tb_nco_hop_ctrl;
  import nco_ctrl_pkg::*;

  localparam int PHI_W      = 32;
  localparam int TBL_DEPTH  = 8;
  localparam int DWELL_W    = 16;
  localparam int SETTLE_CYC = 4;
  localparam int MAXC       = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nco_hop_ctrl_if #(.PHI_W(PHI_W), .TBL_DEPTH(TBL_DEPTH), .DWELL_W(DWELL_W)) bus ();

  nco_hop_ctrl #(
    .PHI_W(PHI_W), .TBL_DEPTH(TBL_DEPTH), .DWELL_W(DWELL_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [31:0] phi;
    logic [2:0]  idx;
    logic        strobe;
    logic        samp;
    logic        busy;
    logic        clken;
    logic        done;
  } obs_t;

  typedef struct {
    int          last;  int dwell; int lp; int vmode;
    int          ncyc;  int stop_c; int wr_c; int wr_a; logic [31:0] wr_d;
    int          e_strobe; int e_done; int e_samp; int e_busy;
    int          e_first;  int e_donec;
    logic [31:0] e_probe;  logic [31:0] e_final;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] mtbl [TBL_DEPTH];
  logic [31:0] mphi;
  obs_t        exp_tr [MAXC];
  logic        vpat [MAXC];
  int          s_strobe, s_done, s_samp, s_busy, s_first, s_donec;
  logic [31:0] s_probe, s_final;
  vec_t        vecs [5];
  vec_t        rv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.phi    = bus.phi_inc_o;
    o.idx    = bus.hop_idx_o;
    o.strobe = bus.hop_strobe_o;
    o.samp   = bus.sample_en_o;
    o.busy   = bus.busy_o;
    o.clken  = bus.nco_clken_o;
    o.done   = bus.done_o;
    return o;
  endfunction

  // Expected per-cycle outputs, built hop by hop: one apply cycle, SETTLE_CYC
  // settle cycles, then run until the dwell count of valid samples is seen.
  task automatic build_model(input int last, input int dwell, input int lp, input int ncyc,
                             input int stop_c, input int wr_c, input int wr_a,
                             input logic [31:0] wr_d);
    int c, h, cnt, need, lst, a;
    logic [31:0] phi;
    bit fin;
    need = (dwell == 0) ? 1 : dwell;
    lst  = (last >= TBL_DEPTH) ? TBL_DEPTH - 1 : last;
    c = 0; h = 0; fin = 0; phi = mphi;
    while (c < ncyc && !fin) begin
      a = c;
      exp_tr[c] = '{phi, 3'(h), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      c++;
      // A table write issued before the apply cycle is visible to it.
      phi = (wr_c >= 0 && wr_c < a && wr_a == h) ? wr_d : mtbl[h];
      for (int s = 0; s < SETTLE_CYC && c < ncyc; s++) begin
        exp_tr[c] = '{phi, 3'(h), (s == 0), 1'b0, 1'b1, 1'b1, 1'b0};
        c++;
      end
      cnt = 0;
      while (c < ncyc && cnt < need) begin
        exp_tr[c] = '{phi, 3'(h), 1'b0, vpat[c], 1'b1, 1'b1, 1'b0};
        if (vpat[c]) cnt++;
        c++;
      end
      if (cnt < need) break;
      if (h < lst) h++;
      else if (lp != 0) h = 0;
      else begin
        if (c < ncyc) begin
          exp_tr[c] = '{phi, 3'(h), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
          c++;
        end
        fin = 1;
      end
    end
    while (c < ncyc) begin
      exp_tr[c] = '{phi, 3'(h), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      c++;
    end
    for (int k = stop_c + 1; k < ncyc; k++)
      exp_tr[k] = '{exp_tr[stop_c].phi, exp_tr[stop_c].idx, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    mphi = exp_tr[stop_c].phi;
    if (wr_c >= 0 && wr_c < ncyc) mtbl[wr_a] = wr_d;
  endtask

  task automatic cfg_write(input int a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'(a); bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    mtbl[a] = d;
  endtask

  task automatic run_seq(input vec_t v);
    obs_t o;
    for (int c = 0; c < v.ncyc; c++)
      vpat[c] = (v.vmode == 0) ? 1'b1 : (v.vmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 9) < 7);
    build_model(v.last, v.dwell, v.lp, v.ncyc, v.stop_c, v.wr_c, v.wr_a, v.wr_d);
    s_strobe = 0; s_done = 0; s_samp = 0; s_busy = 0; s_first = -1; s_donec = -1;
    s_probe = '0; s_final = '0;
    bus.last_idx = 3'(v.last); bus.dwell = 16'(v.dwell); bus.loop_en = (v.lp != 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    // Scramble the config inputs: the sequence must run on the values seen at start.
    bus.last_idx = 3'($urandom);
    bus.dwell    = 16'($urandom_range(0, 7));
    for (int c = 0; c < v.ncyc; c++) begin
      bus.nco_valid_i = vpat[c];
      bus.stop        = (c == v.stop_c);
      bus.start       = exp_tr[c].busy && ($urandom_range(0, 3) == 0);
      bus.cfg_we      = (c == v.wr_c);
      bus.cfg_addr    = 3'(v.wr_a);
      bus.cfg_data    = v.wr_d;
      @(negedge clk);
      o = observe();
      chk($sformatf("trace cyc %0d", c), 64'(o), 64'(exp_tr[c]));
      if (o.strobe) s_strobe++;
      if (o.done) s_done++;
      if (o.samp) s_samp++;
      if (o.busy) s_busy++;
      if (o.samp && s_first < 0) s_first = c;
      if (o.done && s_donec < 0) s_donec = c;
      if (c == 15) s_probe = o.phi;
      if (c == v.ncyc - 1) s_final = o.phi;
      @(posedge clk); #1;
    end
    bus.stop = 1'b0; bus.start = 1'b0; bus.cfg_we = 1'b0; bus.nco_valid_i = 1'b0;
    @(negedge clk);
    chk("idle after sequence busy/clken", 64'({bus.busy_o, bus.nco_clken_o}), 64'(2'b00));
    @(posedge clk); #1;
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.last_idx = '0; bus.dwell = '0; bus.loop_en = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.nco_valid_i = 1'b0;
    mphi = '0;
    for (int i = 0; i < TBL_DEPTH; i++) mtbl[i] = '0;

    #12;
    chk("reset state", 64'(observe()), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    cfg_write(0, 32'h2000_0000);
    cfg_write(1, 32'h1000_0000);
    cfg_write(2, 32'h0800_0000);

    //        last dw lp vm ncyc stop wr_c wr_a wr_d          strb done samp busy first donec probe@15      final
    vecs[0] = '{2, 5, 0, 0, 40, 39, -1, 0, 32'h0,          3, 1, 15, 30, 5, 30, 32'h1000_0000, 32'h0800_0000};
    vecs[1] = '{2, 5, 1, 0, 40, 39, -1, 0, 32'h0,          4, 0, 20, 40, 5, -1, 32'h1000_0000, 32'h2000_0000};
    vecs[2] = '{2, 0, 0, 1, 40, 39, -1, 0, 32'h0,          3, 1,  3, 19, 6, 19, 32'h0800_0000, 32'h0800_0000};
    vecs[3] = '{2, 5, 0, 0, 40, 17, -1, 0, 32'h0,          2, 0,  8, 18, 5, -1, 32'h1000_0000, 32'h1000_0000};
    vecs[4] = '{2, 5, 1, 0, 50, 49, 10, 1, 32'h0400_0000,  5, 0, 25, 50, 5, -1, 32'h1000_0000, 32'h0400_0000};

    for (int i = 0; i < 5; i++) begin
      run_seq(vecs[i]);
      chk($sformatf("vec%0d hop_strobe count", i), 64'(s_strobe), 64'(vecs[i].e_strobe));
      chk($sformatf("vec%0d done count", i),       64'(s_done),   64'(vecs[i].e_done));
      chk($sformatf("vec%0d sample count", i),     64'(s_samp),   64'(vecs[i].e_samp));
      chk($sformatf("vec%0d busy cycles", i),      64'(s_busy),   64'(vecs[i].e_busy));
      chk($sformatf("vec%0d first sample cyc", i), 64'(s_first),  64'(vecs[i].e_first));
      chk($sformatf("vec%0d done cyc", i),         64'(s_donec),  64'(vecs[i].e_donec));
      chk($sformatf("vec%0d phi at cyc 15", i),    64'(s_probe),  64'(vecs[i].e_probe));
      chk($sformatf("vec%0d final phi", i),        64'(s_final),  64'(vecs[i].e_final));
    end

    // stop together with start in IDLE: stays idle.
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    chk("stop beats start busy/clken", 64'({bus.busy_o, bus.nco_clken_o}), 64'(2'b00));
    @(posedge clk); #1;

    // Reset in the middle of SETTLE: outputs clear without waiting for a clock.
    bus.last_idx = 3'd2; bus.dwell = 16'd5; bus.loop_en = 1'b0; bus.nco_valid_i = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async reset outputs", 64'(observe()), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.nco_valid_i = 1'b0;
    mphi = '0;
    for (int i = 0; i < TBL_DEPTH; i++) mtbl[i] = '0;
    rv = '{2, 2, 0, 0, 40, 39, -1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0};
    run_seq(rv);
    chk("post-reset hop_strobe count", 64'(s_strobe), 64'(3));
    chk("post-reset phi from cleared table", 64'(s_final), 64'(0));

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        cfg_write(int'($urandom_range(0, TBL_DEPTH - 1)), $urandom);
      rv.last   = int'($urandom_range(0, TBL_DEPTH - 1));
      rv.dwell  = int'($urandom_range(0, 3));
      rv.lp     = int'($urandom_range(0, 1));
      rv.vmode  = 2;
      rv.ncyc   = 60;
      rv.stop_c = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 59)) : 59;
      rv.wr_c   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 59)) : -1;
      rv.wr_a   = int'($urandom_range(0, TBL_DEPTH - 1));
      rv.wr_d   = $urandom;
      run_seq(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nco_hop_ctrl.md
NCO_HOP_CTRL -- requirements
Module: nco_hop_ctrl

Interface
REQ-001 The block SHALL have parameter PHI_W, default 32, giving the phase-increment width.
REQ-002 The block SHALL have parameter TBL_DEPTH, default 8, giving the number of hop-table entries.
REQ-003 The block SHALL have parameter DWELL_W, default 16, giving the dwell-counter width.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4, giving the NCO pipeline settle cycles.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 cfg_we  in  1  hop-table write strobe.
REQ-008 cfg_addr  in  log2(TBL_DEPTH)  table write index.
REQ-009 cfg_data  in  PHI_W  phase increment to store.
REQ-010 last_idx  in  log2(TBL_DEPTH)  index of final hop in sequence.
REQ-011 dwell  in  DWELL_W  valid NCO samples per hop; 0 treated as 1.
REQ-012 loop_en  in  1  restart at index 0 after last hop.
REQ-013 start  in  1  single-cycle sequence start.
REQ-014 stop  in  1  single-cycle abort.
REQ-015 nco_valid_i  in  1  NCO out_valid.
REQ-016 phi_inc_o  out  PHI_W  drives NCO phi_inc_i.
REQ-017 nco_clken_o  out  1  drives NCO clken.
REQ-018 hop_idx_o  out  log2(TBL_DEPTH)  current hop index.
REQ-019 hop_strobe_o  out  1  one-cycle pulse on each new phi_inc_o value.
REQ-020 sample_en_o  out  1  NCO sample is usable (counted toward dwell).
REQ-021 busy_o  out  1  sequence active.
REQ-022 done_o  out  1  one-cycle pulse at non-looping sequence end.

Function
REQ-023 FSM states SHALL be IDLE, APPLY, SETTLE, RUN, DONE.
REQ-024 IDLE + start (stop low) -> APPLY with idx=0; start in any other state SHALL be ignored.
REQ-025 APPLY (1 cycle): phi_inc_o <= table[idx], hop_strobe_o=1 next cycle, settle counter <= SETTLE_CYC-1, -> SETTLE.
REQ-026 SETTLE: counter decrements each cycle; at 0 -> RUN with dwell counter cleared; SETTLE lasts exactly SETTLE_CYC cycles.
REQ-027 RUN: sample_en_o = nco_valid_i (combinational, zero latency); dwell counter increments per sample_en_o.
REQ-028 RUN exit on the sample that makes count equal max(dwell,1): idx<last_idx -> idx+1, APPLY; idx==last_idx and loop_en -> idx=0, APPLY; else -> DONE.
REQ-029 dwell and last_idx SHALL be sampled at start and held for the sequence.
REQ-030 DONE (1 cycle): done_o=1, -> IDLE.
REQ-031 stop SHALL force IDLE next cycle from any state; stop wins over simultaneous start and over a RUN-exit transition; done_o not asserted on stop.
REQ-032 nco_clken_o=1 in APPLY, SETTLE, RUN; 0 in IDLE, DONE.
REQ-033 busy_o=1 in APPLY, SETTLE, RUN.
REQ-034 phi_inc_o SHALL hold its last value in IDLE/DONE.
REQ-035 Table writes SHALL be accepted in every state; same-cycle write and APPLY read of one address SHALL return the old value.
REQ-036 last_idx >= TBL_DEPTH SHALL be clamped to TBL_DEPTH-1.

Reset
REQ-037 On reset_n low: state IDLE, phi_inc_o=0, hop_idx_o=0, all strobes/flags 0, counters 0; table contents SHALL reset to 0.
REQ-038 Reset mid-sequence SHALL abort immediately with no done_o.

Structure
REQ-039 State enum and default parameter constants SHALL live in shared package nco_ctrl_pkg.
REQ-040 Hop table SHALL be sub-module nco_hop_table (sync write, async read, async reset).

Verification
REQ-041 Load table {0x20000000,0x10000000,0x08000000}, last_idx=2, dwell=5, loop_en=0, nco_valid_i=1, start -> phi_inc_o steps through the three values, hop_strobe_o 3 pulses, 4 SETTLE cycles each, done_o once, busy_o low after.
REQ-042 Same setup with loop_en=1 -> after index 2 phi_inc_o returns to 0x20000000, no done_o.
REQ-043 dwell=0, nco_valid_i toggling 1/0 -> exactly one sample counted per hop.
REQ-044 stop asserted on 3rd RUN sample of hop 1 -> IDLE next cycle, nco_clken_o=0, done_o never asserted, phi_inc_o holds 0x10000000.
REQ-045 cfg_we to addr 1 with 0x04000000 on the APPLY cycle of hop 1 -> hop 1 uses old 0x10000000; next loop uses 0x04000000.
REQ-046 reset_n low during SETTLE -> all outputs zero asynchronously, table cleared.
